// File: rtl/dff_segment_serializer_pkg.sv
// Shared defaults and the transfer-operation type for the FFT output segment serializer.
package dff_segment_serializer_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 8;

    // One operation per cycle. Load and bypass outrank the final shift,
    // which is what lets back-to-back bursts run without a bubble.
    typedef enum logic [1:0] {
        OP_NONE,
        OP_SHIFT,
        OP_LOAD,
        OP_BYPASS
    } xfer_op_e;

endpackage

// File: rtl/dff_segment_serializer_if.sv
// Load, bypass, output stream and control signals of the segment serializer.
interface dff_segment_serializer_if
    import dff_segment_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
);
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);

    logic                        hold;
    logic                        bypass;
    logic                        load_valid;
    logic                        load_ready;
    logic [DEPTH*DATA_WIDTH-1:0] load_data;
    logic                        byp_valid;
    logic                        byp_ready;
    logic [DATA_WIDTH-1:0]       byp_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_WIDTH-1:0]       out_data;
    logic                        out_last;
    logic [CNT_WIDTH-1:0]        count;

    modport slave (
        input  hold, bypass, load_valid, load_data, byp_valid, byp_data, out_ready,
        output load_ready, byp_ready, out_valid, out_data, out_last, count
    );

    modport master (
        output hold, bypass, load_valid, load_data, byp_valid, byp_data, out_ready,
        input  load_ready, byp_ready, out_valid, out_data, out_last, count
    );

endinterface

// File: rtl/dff_word_cell_sync_low_reset.sv
// One word register of the serializer: parallel load or shift from the next cell.
module dff_word_cell_sync_low_reset #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] load_d,
    input  logic [DATA_WIDTH-1:0] shift_d,
    output logic [DATA_WIDTH-1:0] q
);

    // NOTE: reset is synchronous and active-low, so it lives inside the clocked
    // branch; the word registers are reset too because out_data must read 0 after reset.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (hold) begin
            q <= q;
        end else if (load) begin
            q <= load_d;
        end else if (shift) begin
            q <= shift_d;
        end
    end

endmodule

// File: rtl/dff_segment_serializer.sv
// Parallel-in/serial-out output segment: DEPTH-word loads or single bypass words out a valid/ready stream.
module dff_segment_serializer
    import dff_segment_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input logic                     clk,
    input logic                     rst,
    dff_segment_serializer_if.slave bus
);

    localparam int CNT_WIDTH = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] sr [DEPTH];
    logic [CNT_WIDTH-1:0]  count_q;
    logic                  free;
    logic                  out_fire;
    xfer_op_e              op;

    // out_ready reaches the readies combinationally: the last word leaving frees the slot.
    assign free          = !bus.hold && ((count_q == '0) ||
                           ((count_q == CNT_WIDTH'(1)) && bus.out_ready));
    assign bus.load_ready = free && !bus.bypass;
    assign bus.byp_ready  = free && bus.bypass;
    assign bus.out_valid  = !bus.hold && (count_q != '0);
    assign bus.out_last   = (count_q == CNT_WIDTH'(1));
    assign bus.out_data   = sr[0];
    assign bus.count      = count_q;
    assign out_fire       = bus.out_valid && bus.out_ready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        op = OP_NONE;
        if (bus.load_valid && bus.load_ready) begin
            op = OP_LOAD;
        end else if (bus.byp_valid && bus.byp_ready) begin
            op = OP_BYPASS;
        end else if (out_fire) begin
            op = OP_SHIFT;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        logic [DATA_WIDTH-1:0] load_d;
        logic [DATA_WIDTH-1:0] shift_d;
        logic                  load;

        if (i == 0) begin : g_head
            assign load_d = (op == OP_BYPASS) ? bus.byp_data : bus.load_data[0 +: DATA_WIDTH];
            assign load   = (op == OP_LOAD) || (op == OP_BYPASS);
        end else begin : g_body
            assign load_d = bus.load_data[i*DATA_WIDTH +: DATA_WIDTH];
            assign load   = (op == OP_LOAD);
        end

        if (i == DEPTH - 1) begin : g_tail
            assign shift_d = '0;
        end else begin : g_link
            assign shift_d = sr[i+1];
        end

        dff_word_cell_sync_low_reset #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .hold    (bus.hold),
            .load    (load),
            .shift   (op == OP_SHIFT),
            .load_d  (load_d),
            .shift_d (shift_d),
            .q       (sr[i])
        );
    end

    // Hold needs no branch here: every fire term is already gated by !hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            case (op)
                OP_LOAD:   count_q <= CNT_WIDTH'(DEPTH);
                OP_BYPASS: count_q <= CNT_WIDTH'(1);
                OP_SHIFT:  count_q <= count_q - CNT_WIDTH'(1);
                default:   count_q <= count_q;
            endcase
        end
    end

endmodule
